wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the pipeline write-back result (resultW path) and a
//  multi-cycle unit (mul/div) that returns results late. Pipeline writes always win; multi-cycle results
//  queue in a small FIFO and drain in idle slots. Anti-starvation stall request; stale-write kill on
//  same-register overwrite. Sits between the write-back stage / multi-cycle unit and the register file.
// PARAMETERS
//  DATA_W    19  width of write data
//  ADDR_W     3  register address width
//  DEPTH      2  multi-cycle result FIFO depth (power of 2, >=2)
//  MAX_WAIT   4  consecutive lost arbitration cycles before stall_req asserts (>=1)
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              asynchronous, active-low reset
//  pipe_we    in   1              pipeline write-back valid
//  pipe_rd    in   ADDR_W         pipeline destination register
//  pipe_data  in   DATA_W         pipeline result (resultW)
//  mc_valid   in   1              multi-cycle result valid
//  mc_ready   out  1              FIFO can accept (= !full)
//  mc_rd      in   ADDR_W         multi-cycle destination register
//  mc_data    in   DATA_W         multi-cycle result
//  rf_we      out  1              register file write enable (registered)
//  rf_rd      out  ADDR_W         register file write address (registered)
//  rf_wd      out  DATA_W         register file write data (registered)
//  stall_req  out  1              request pipeline bubble so FIFO can drain (registered)
//  fifo_cnt   out  $clog2(DEPTH)+1 FIFO occupancy
// BEHAVIOUR
//  - Reset (rst=0, async): rf_we=0, rf_rd=0, rf_wd=0, stall_req=0, FIFO empty, wait_cnt=0; mc_ready=1.
//  - Push: mc_valid && mc_ready stores {kill=0, mc_rd, mc_data} at tail. mc_ready depends only on count,
//    not on a same-cycle pop (full FIFO refuses even while draining).
//  - Arbitration each cycle, fixed priority: pipe_we=1 -> grant pipeline; else FIFO non-empty -> pop head;
//    else idle. No bypass: an entry pushed this cycle is poppable next cycle at earliest.
//  - Output regs, latency 1: pipeline grant -> rf_we=1, rf_rd=pipe_rd, rf_wd=pipe_data next cycle.
//    Pop -> rf_rd/rf_wd = head, rf_we = !head.kill. Idle -> rf_we=0, rf_rd/rf_wd hold.
//  - Kill: pipe_we=1 with pipe_rd equal to rd of any valid FIFO entry sets that entry's kill bit (older
//    value must not overwrite younger). Entry pushed in the same cycle is not compared; killed entries
//    still occupy a slot and are popped normally with rf_we=0.
//  - Starvation: wait_cnt increments each cycle FIFO non-empty and pipe_we=1, saturating at MAX_WAIT;
//    clears on every pop and when FIFO empty. stall_req=1 the cycle after wait_cnt reaches MAX_WAIT,
//    held until the cycle after the next pop. If pipe_we arrives while stall_req=1 the pipeline still wins.
//  - fifo_cnt = entries held; push+pop same cycle leaves count unchanged; pointers wrap modulo DEPTH.
//  - Reset mid-operation discards FIFO contents and any pending write; no rf_we after reset release
//    until a new grant.
// TESTING
//  1 Reset: rst=0 mid-stream -> rf_we=0, stall_req=0, fifo_cnt=0, mc_ready=1 immediately.
//  2 Pipeline only: pipe_we=1, rd=5, data=19'h1ABCD -> next cycle rf_we=1, rf_rd=5, rf_wd=19'h1ABCD.
//  3 Queue/drain: push rd=2 d=0x00111 and rd=3 d=0x00222, pipe idle -> writes rd=2 then rd=3 on cycles
//    +2,+3; mc_ready=0 while fifo_cnt=2.
//  4 Starvation: one entry queued, pipe_we=1 for 4 cycles -> stall_req=1 on 5th cycle; pipe_we=0 ->
//    entry written next cycle, stall_req drops the cycle after pop.
//  5 Kill: queue rd=4 d=0x00AAA, then pipe_we rd=4 d=0x00BBB -> rf shows 0x00BBB; later pop has rf_we=0.
//  6 Full + simultaneous: FIFO full, pop and mc_valid same cycle -> push refused, fifo_cnt=1 after.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back always wins, late multi-cycle
// results wait in a small FIFO, drain in idle slots, and are killed if overwritten first.
module wb_port_arbiter #(
  parameter int DATA_W   = 19,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_we,
  input  logic [ADDR_W-1:0]      pipe_rd,
  input  logic [DATA_W-1:0]      pipe_data,
  input  logic                   mc_valid,
  output logic                   mc_ready,
  input  logic [ADDR_W-1:0]      mc_rd,
  input  logic [DATA_W-1:0]      mc_data,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_rd,
  output logic [DATA_W-1:0]      rf_wd,
  output logic                   stall_req,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [ADDR_W-1:0] r_mem_rd   [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [DEPTH-1:0]  r_kill;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_stall;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_rd;
  logic [DATA_W-1:0] r_rf_wd;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DEPTH-1:0]  w_kill_hit;
  logic [WAIT_W-1:0] w_wait_nxt;

  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_empty = (r_cnt == '0);
  // Readiness looks only at occupancy, so a full FIFO refuses even while it drains.
  assign w_push  = mc_valid && !w_full;
  assign w_pop   = !pipe_we && !w_empty;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_kill_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill_hit[i] = pipe_we && r_vld[i] && (r_mem_rd[i] == pipe_rd);
    end
  end

  always_comb begin
    w_wait_nxt = r_wait;
    if (w_empty || w_pop) begin
      w_wait_nxt = '0;
    end else if (r_wait != WAIT_W'(MAX_WAIT)) begin
      w_wait_nxt = r_wait + WAIT_W'(1);
    end
  end

  // NOTE: payload storage has no reset; occupancy is tracked by r_vld/r_cnt, which are reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= mc_rd;
      r_mem_data[r_wptr] <= mc_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld   <= '0;
      r_kill  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_stall <= 1'b0;
      r_rf_we <= 1'b0;
      r_rf_rd <= '0;
      r_rf_wd <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wptr == PTR_W'(i))) begin
          r_vld[i]  <= 1'b1;
          r_kill[i] <= 1'b0;
        end else if (w_pop && (r_rptr == PTR_W'(i))) begin
          r_vld[i]  <= 1'b0;
        end else if (w_kill_hit[i]) begin
          r_kill[i] <= 1'b1;
        end
      end

      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase

      // Saturated wait only clears on a pop, so stall stays up until the FIFO gets a slot.
      r_wait  <= w_wait_nxt;
      r_stall <= (w_wait_nxt == WAIT_W'(MAX_WAIT));

      if (pipe_we) begin
        r_rf_we <= 1'b1;
        r_rf_rd <= pipe_rd;
        r_rf_wd <= pipe_data;
      end else if (w_pop) begin
        r_rf_we <= !r_kill[r_rptr];
        r_rf_rd <= r_mem_rd[r_rptr];
        r_rf_wd <= r_mem_data[r_rptr];
      end else begin
        r_rf_we <= 1'b0;
      end
    end
  end

  assign mc_ready  = !w_full;
  assign rf_we     = r_rf_we;
  assign rf_rd     = r_rf_rd;
  assign rf_wd     = r_rf_wd;
  assign stall_req = r_stall;
  assign fifo_cnt  = r_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model of the write-port sharing rules.
module tb_wb_port_arbiter;

  localparam int DATA_W   = 19;
  localparam int ADDR_W   = 3;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              mc_valid;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_rd;
  logic [DATA_W-1:0] mc_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wd;
  logic              stall_req;
  logic [1:0]        fifo_cnt;

  int n_checks = 0;
  int n_errors = 0;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .stall_req(stall_req), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending multi-cycle results in arrival order.
  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    bit                kill;
  } ent_t;

  ent_t              q[$];
  int                m_lost;
  logic              m_we;
  logic [ADDR_W-1:0] m_rd;
  logic [DATA_W-1:0] m_wd;

  task automatic drive_idle();
    pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_pipe(input logic we, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    pipe_we = we; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic set_mc(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    mc_valid = v; mc_rd = rd; mc_data = d;
  endtask

  // One clock edge of the rules: pipeline wins, else oldest pending result is written.
  task automatic model_step();
    ent_t e;
    bit   accept;
    accept = mc_valid && (q.size() < DEPTH);
    if (pipe_we) begin
      foreach (q[i]) if (q[i].rd == pipe_rd) q[i].kill = 1'b1;
      m_we = 1'b1; m_rd = pipe_rd; m_wd = pipe_data;
      m_lost = (q.size() == 0) ? 0 : ((m_lost < MAX_WAIT) ? m_lost + 1 : MAX_WAIT);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = !e.kill; m_rd = e.rd; m_wd = e.data;
      m_lost = 0;
    end else begin
      m_we = 1'b0;
      m_lost = 0;
    end
    if (accept) begin
      e.rd = mc_rd; e.data = mc_data; e.kill = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    n_checks++; if (rf_we !== 1'b0)     begin n_errors++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
    n_checks++; if (rf_rd !== '0)       begin n_errors++; $display("FAIL reset_rf_rd: got %0d want 0", rf_rd); end
    n_checks++; if (rf_wd !== '0)       begin n_errors++; $display("FAIL reset_rf_wd: got %h want 0", rf_wd); end
    n_checks++; if (stall_req !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b want 0", stall_req); end
    n_checks++; if (fifo_cnt !== 2'd0)  begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
    n_checks++; if (mc_ready !== 1'b1)  begin n_errors++; $display("FAIL reset_ready: got %0b want 1", mc_ready); end
    rst = 1'b1;
    set_pipe(1'b1, 3'd7, 19'h00007);
    set_mc(1'b1, 3'd6, 19'h00066);
    tick();
    tick();
    n_checks++; if (fifo_cnt !== 2'd2) begin n_errors++; $display("FAIL midrst_fill: got %0d want 2", fifo_cnt); end
    rst = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b0)     begin n_errors++; $display("FAIL midrst_rf_we: got %0b want 0", rf_we); end
    n_checks++; if (stall_req !== 1'b0) begin n_errors++; $display("FAIL midrst_stall: got %0b want 0", stall_req); end
    n_checks++; if (fifo_cnt !== 2'd0)  begin n_errors++; $display("FAIL midrst_cnt: got %0d want 0", fifo_cnt); end
    n_checks++; if (mc_ready !== 1'b1)  begin n_errors++; $display("FAIL midrst_ready: got %0b want 1", mc_ready); end
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (rf_we !== 1'b0)    begin n_errors++; $display("FAIL postrst_we[%0d]: got %0b want 0", k, rf_we); end
      n_checks++; if (fifo_cnt !== 2'd0) begin n_errors++; $display("FAIL postrst_cnt[%0d]: got %0d want 0", k, fifo_cnt); end
    end
  endtask

  task automatic test_pipeline();
    set_pipe(1'b1, 3'd5, 19'h1ABCD);
    tick();
    n_checks++; if (rf_we !== 1'b1)     begin n_errors++; $display("FAIL pipe_we: got %0b want 1", rf_we); end
    n_checks++; if (rf_rd !== 3'd5)     begin n_errors++; $display("FAIL pipe_rd: got %0d want 5", rf_rd); end
    n_checks++; if (rf_wd !== 19'h1ABCD) begin n_errors++; $display("FAIL pipe_wd: got %h want 1abcd", rf_wd); end
    drive_idle();
    tick();
    n_checks++; if (rf_we !== 1'b0)     begin n_errors++; $display("FAIL idle_we: got %0b want 0", rf_we); end
    n_checks++; if (rf_rd !== 3'd5 || rf_wd !== 19'h1ABCD)
      begin n_errors++; $display("FAIL idle_hold: got %0d/%h want 5/1abcd", rf_rd, rf_wd); end
  endtask

  task automatic test_queue_drain();
    set_mc(1'b1, 3'd2, 19'h00111);
    tick();
    n_checks++; if (fifo_cnt !== 2'd1 || rf_we !== 1'b0)
      begin n_errors++; $display("FAIL qd_push1: got cnt=%0d we=%0b want 1/0", fifo_cnt, rf_we); end
    set_mc(1'b1, 3'd3, 19'h00222);
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_rd !== 3'd2 || rf_wd !== 19'h00111)
      begin n_errors++; $display("FAIL qd_first: got %0b/%0d/%h want 1/2/00111", rf_we, rf_rd, rf_wd); end
    n_checks++; if (fifo_cnt !== 2'd1) begin n_errors++; $display("FAIL qd_cnt: got %0d want 1", fifo_cnt); end
    drive_idle();
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_rd !== 3'd3 || rf_wd !== 19'h00222)
      begin n_errors++; $display("FAIL qd_second: got %0b/%0d/%h want 1/3/00222", rf_we, rf_rd, rf_wd); end
    tick();
    n_checks++; if (rf_we !== 1'b0 || fifo_cnt !== 2'd0)
      begin n_errors++; $display("FAIL qd_done: got we=%0b cnt=%0d want 0/0", rf_we, fifo_cnt); end
  endtask

  task automatic test_starvation();
    set_mc(1'b1, 3'd6, 19'h00333);
    tick();
    mc_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_pipe(1'b1, 3'd1, DATA_W'(k));
      tick();
      n_checks++; if (stall_req !== (k >= 4))
        begin n_errors++; $display("FAIL starve_stall[%0d]: got %0b want %0b", k, stall_req, (k >= 4)); end
      n_checks++; if (rf_we !== 1'b1 || rf_wd !== DATA_W'(k) || fifo_cnt !== 2'd1)
        begin n_errors++; $display("FAIL starve_pipe[%0d]: got %0b/%h/%0d want 1/%h/1", k, rf_we, rf_wd, fifo_cnt, DATA_W'(k)); end
    end
    drive_idle();
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_rd !== 3'd6 || rf_wd !== 19'h00333)
      begin n_errors++; $display("FAIL starve_pop: got %0b/%0d/%h want 1/6/00333", rf_we, rf_rd, rf_wd); end
    n_checks++; if (stall_req !== 1'b0 || fifo_cnt !== 2'd0)
      begin n_errors++; $display("FAIL starve_release: got stall=%0b cnt=%0d want 0/0", stall_req, fifo_cnt); end
  endtask

  task automatic test_kill();
    set_mc(1'b1, 3'd4, 19'h00AAA);
    tick();
    mc_valid = 1'b0;
    set_pipe(1'b1, 3'd4, 19'h00BBB);
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_rd !== 3'd4 || rf_wd !== 19'h00BBB)
      begin n_errors++; $display("FAIL kill_pipe: got %0b/%0d/%h want 1/4/00bbb", rf_we, rf_rd, rf_wd); end
    drive_idle();
    tick();
    n_checks++; if (rf_we !== 1'b0 || fifo_cnt !== 2'd0)
      begin n_errors++; $display("FAIL kill_pop: got we=%0b cnt=%0d want 0/0", rf_we, fifo_cnt); end
    // A result pushed alongside a same-register pipeline write is younger and survives.
    set_mc(1'b1, 3'd4, 19'h00CCC);
    set_pipe(1'b1, 3'd4, 19'h00DDD);
    tick();
    drive_idle();
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_wd !== 19'h00CCC)
      begin n_errors++; $display("FAIL kill_samecycle: got %0b/%h want 1/00ccc", rf_we, rf_wd); end
  endtask

  task automatic test_full_simultaneous();
    set_pipe(1'b1, 3'd0, 19'h00001);
    set_mc(1'b1, 3'd1, 19'h00101);
    tick();
    set_mc(1'b1, 3'd2, 19'h00202);
    tick();
    n_checks++; if (fifo_cnt !== 2'd2 || mc_ready !== 1'b0)
      begin n_errors++; $display("FAIL full_state: got cnt=%0d ready=%0b want 2/0", fifo_cnt, mc_ready); end
    pipe_we = 1'b0;
    set_mc(1'b1, 3'd3, 19'h00303);
    tick();
    n_checks++; if (fifo_cnt !== 2'd1 || mc_ready !== 1'b1)
      begin n_errors++; $display("FAIL full_refuse: got cnt=%0d ready=%0b want 1/1", fifo_cnt, mc_ready); end
    n_checks++; if (rf_we !== 1'b1 || rf_rd !== 3'd1 || rf_wd !== 19'h00101)
      begin n_errors++; $display("FAIL full_pop1: got %0b/%0d/%h want 1/1/00101", rf_we, rf_rd, rf_wd); end
    drive_idle();
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_rd !== 3'd2 || rf_wd !== 19'h00202)
      begin n_errors++; $display("FAIL full_pop2: got %0b/%0d/%h want 1/2/00202", rf_we, rf_rd, rf_wd); end
    tick();
    n_checks++; if (rf_we !== 1'b0 || fifo_cnt !== 2'd0)
      begin n_errors++; $display("FAIL full_refused_lost: got we=%0b cnt=%0d want 0/0", rf_we, fifo_cnt); end
  endtask

  task automatic test_random();
    int p_pipe;
    int p_mc;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    q.delete();
    m_lost = 0; m_we = 1'b0; m_rd = '0; m_wd = '0;
    rst = 1'b1;
    p_pipe = 50; p_mc = 50;
    for (int cyc = 0; cyc < 800; cyc++) begin
      n_checks++; if (rf_we !== m_we)   begin n_errors++; $display("FAIL rnd_we@%0d: got %0b want %0b", cyc, rf_we, m_we); end
      n_checks++; if (rf_rd !== m_rd)   begin n_errors++; $display("FAIL rnd_rd@%0d: got %0d want %0d", cyc, rf_rd, m_rd); end
      n_checks++; if (rf_wd !== m_wd)   begin n_errors++; $display("FAIL rnd_wd@%0d: got %h want %h", cyc, rf_wd, m_wd); end
      n_checks++; if (fifo_cnt !== 2'(q.size()))
        begin n_errors++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", cyc, fifo_cnt, q.size()); end
      n_checks++; if (mc_ready !== (q.size() < DEPTH))
        begin n_errors++; $display("FAIL rnd_ready@%0d: got %0b want %0b", cyc, mc_ready, (q.size() < DEPTH)); end
      n_checks++; if (stall_req !== (m_lost == MAX_WAIT))
        begin n_errors++; $display("FAIL rnd_stall@%0d: got %0b want %0b", cyc, stall_req, (m_lost == MAX_WAIT)); end
      if (cyc % 64 == 0) begin
        p_pipe = (cyc % 192 == 0) ? 90 : ((cyc % 128 == 0) ? 20 : 55);
        p_mc   = ($urandom_range(0, 1) == 1) ? 70 : 30;
      end
      set_pipe($urandom_range(0, 99) < p_pipe, ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
      set_mc($urandom_range(0, 99) < p_mc, ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_queue_drain();
    test_starvation();
    test_kill();
    test_full_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
